// File: rtl/ex_muldiv.sv
// Multi-cycle multiply/divide unit for the EX stage.
// Produces a {HI,LO} result and stalls the pipeline while busy.
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [2:0]         op_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic [2*WIDTH-1:0] hilo_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stall_o
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV_ON,
        DIV_ZERO,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [W2-1:0]     hilo_q, hilo_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  quot_q, quot_d;
    logic [W2-1:0]     result_q, result_d;

    logic              is_signed;
    logic              a_neg;
    logic              b_neg;
    logic [W2-1:0]     a_ext;
    logic [W2-1:0]     b_ext;
    logic [W2-1:0]     prod;
    logic [WIDTH-1:0]  dsr_mag;
    logic [WIDTH-1:0]  dvd_mag;
    logic [WIDTH:0]    shifted;
    logic [WIDTH:0]    diff;
    logic [WIDTH-1:0]  rem_nx;
    logic [WIDTH-1:0]  quot_nx;
    logic [WIDTH-1:0]  rem_fix;
    logic [WIDTH-1:0]  quot_fix;

    // Even op codes are the signed variants in both families.
    assign is_signed = ~op_q[0];
    assign a_neg     = is_signed & a_q[WIDTH-1];
    assign b_neg     = is_signed & b_q[WIDTH-1];

    assign a_ext = is_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q}
                             : {{WIDTH{1'b0}}, a_q};
    assign b_ext = is_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q}
                             : {{WIDTH{1'b0}}, b_q};
    assign prod  = a_ext * b_ext;

    assign dsr_mag = b_neg ? -b_q : b_q;
    assign dvd_mag = (~op_i[0] & opdata1_i[WIDTH-1]) ? -opdata1_i
                                                     : opdata1_i;

    // One restoring step: shift in the next dividend bit, try subtract.
    assign shifted = {rem_q, quot_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dsr_mag};
    assign rem_nx  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quot_nx = {quot_q[WIDTH-2:0], ~diff[WIDTH]};

    assign quot_fix = (a_neg ^ b_neg) ? -quot_nx : quot_nx;
    assign rem_fix  = a_neg ? -rem_nx : rem_nx;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hilo_d   = hilo_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (start_i && !annul_i) begin
                    op_d   = op_i;
                    a_d    = opdata1_i;
                    b_d    = opdata2_i;
                    hilo_d = hilo_i;
                    cnt_d  = '0;
                    rem_d  = '0;
                    quot_d = dvd_mag;
                    if (op_i == 3'd2 || op_i == 3'd3) begin
                        state_d = (opdata2_i == '0) ? DIV_ZERO : DIV_ON;
                    end else begin
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                if (annul_i || !start_i) begin
                    state_d = IDLE;
                end else begin
                    if (!op_q[2]) begin
                        result_d = prod;
                    end else if (op_q[1]) begin
                        result_d = hilo_q - prod;
                    end else begin
                        result_d = hilo_q + prod;
                    end
                    state_d = DONE;
                end
            end
            DIV_ON: begin
                if (annul_i || !start_i) begin
                    state_d = IDLE;
                end else begin
                    rem_d  = rem_nx;
                    quot_d = quot_nx;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        result_d = {rem_fix, quot_fix};
                        state_d  = DONE;
                    end
                end
            end
            DIV_ZERO: begin
                if (annul_i || !start_i) begin
                    state_d = IDLE;
                end else begin
                    result_d = {a_q, {WIDTH{1'b1}}};
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (annul_i || !start_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hilo_q   <= '0;
            cnt_q    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hilo_q   <= hilo_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            result_q <= result_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = (state_q == DONE);
    assign stall_o  = start_i & ~annul_i & ~ready_o;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed, table-driven bench for ex_muldiv.
// Vector table plus hand sequences for annul, reset and held start.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] hilo_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] hilo;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[12];

    ex_muldiv #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .op_i      (op_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .hilo_i    (hilo_i),
        .annul_i   (annul_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .stall_o   (stall_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Start in cycle N, wait for ready, check latency/stall/result,
    // hold start for a few DONE cycles, then release.
    task automatic run_op(input vec_t v);
        int  cyc;
        logic stall_bad;
        @(negedge clk);
        op_i      = v.op;
        opdata1_i = v.a;
        opdata2_i = v.b;
        hilo_i    = v.hilo;
        start_i   = 1'b1;
        #1;
        stall_bad = !stall_o;
        cyc = 0;
        while (!ready_o && cyc < 100) begin
            @(negedge clk);
            cyc++;
            // operands change after latching and must be ignored
            opdata1_i = ~v.a;
            opdata2_i = 32'h0;
            hilo_i    = ~v.hilo;
            if (!ready_o && !stall_o) stall_bad = 1'b1;
        end
        chk({v.name, " latency"}, 64'(cyc), 64'(v.lat));
        chk({v.name, " result"}, result_o, v.exp);
        chk({v.name, " stall_busy"}, {63'd0, stall_bad}, 64'd0);
        chk({v.name, " stall_ready"}, {63'd0, stall_o}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk({v.name, " held_ready"}, {63'd0, ready_o}, 64'd1);
            chk({v.name, " held_result"}, result_o, v.exp);
        end
        start_i = 1'b0;
        @(negedge clk);
        chk({v.name, " ready_drop"}, {63'd0, ready_o}, 64'd0);
        chk({v.name, " idle_result"}, result_o, v.exp);
    endtask

    initial begin
        logic [63:0] prior;
        logic        saw_ready;
        vec_t        v;

        tbl[0]  = '{"mult",   3'd0, 32'hFFFFFFFF, 32'h2, 64'h0,
                    64'hFFFFFFFF_FFFFFFFE, 2};
        tbl[1]  = '{"multu",  3'd1, 32'hFFFFFFFF, 32'h2, 64'h0,
                    64'h00000001_FFFFFFFE, 2};
        tbl[2]  = '{"madd",   3'd4, 32'h3, 32'h4, 64'h1,
                    64'h00000000_0000000D, 2};
        tbl[3]  = '{"msubu",  3'd7, 32'h1, 32'h1, 64'h0,
                    64'hFFFFFFFF_FFFFFFFF, 2};
        tbl[4]  = '{"msub",   3'd6, 32'hFFFFFFFE, 32'h3, 64'h10,
                    64'h00000000_00000016, 2};
        tbl[5]  = '{"maddu",  3'd5, 32'h1, 32'h1, 64'hFFFFFFFF_FFFFFFFF,
                    64'h0, 2};
        tbl[6]  = '{"div_n7_2", 3'd2, 32'hFFFFFFF9, 32'h2, 64'h0,
                    64'hFFFFFFFF_FFFFFFFD, 33};
        tbl[7]  = '{"divu_big", 3'd3, 32'hFFFFFFFF, 32'h10, 64'h0,
                    64'h0000000F_0FFFFFFF, 33};
        tbl[8]  = '{"div_min", 3'd2, 32'h80000000, 32'hFFFFFFFF, 64'h0,
                    64'h00000000_80000000, 33};
        tbl[9]  = '{"divu_zero", 3'd3, 32'h5, 32'h0, 64'h0,
                    64'h00000005_FFFFFFFF, 2};
        tbl[10] = '{"div_7_n2", 3'd2, 32'h7, 32'hFFFFFFFE, 64'h0,
                    64'h00000001_FFFFFFFD, 33};
        tbl[11] = '{"div_0_5", 3'd2, 32'h0, 32'h5, 64'h0,
                    64'h0, 33};

        rst       = 1'b1;
        start_i   = 1'b1;
        op_i      = 3'd0;
        opdata1_i = '0;
        opdata2_i = '0;
        hilo_i    = '0;
        annul_i   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset ready", {63'd0, ready_o}, 64'd0);
        chk("reset result", result_o, 64'd0);
        chk("reset stall", {63'd0, stall_o}, 64'd1);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) run_op(tbl[i]);

        // annul at N+10 of a divide: no ready, result unchanged
        prior = tbl[11].exp;
        @(negedge clk);
        op_i      = 3'd2;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        #1;
        chk("annul stall", {63'd0, stall_o}, 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        saw_ready = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) saw_ready = 1'b1;
        end
        chk("annul no_ready", {63'd0, saw_ready}, 64'd0);
        chk("annul result_kept", result_o, prior);

        v = '{"mult_after_annul", 3'd0, 32'h7, 32'hFFFFFFFD, 64'h0,
              64'hFFFFFFFF_FFFFFFEB, 2};
        run_op(v);

        // reset at N+5 of a divide
        @(negedge clk);
        op_i      = 3'd3;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        start_i = 1'b0;
        chk("rst ready", {63'd0, ready_o}, 64'd0);
        chk("rst result", result_o, 64'd0);
        saw_ready = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) saw_ready = 1'b1;
        end
        chk("rst no_ready", {63'd0, saw_ready}, 64'd0);

        v = '{"divu_after_rst", 3'd3, 32'd1000, 32'd3, 64'h0,
              64'h00000001_0000014D, 33};
        run_op(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Parametrised multi-cycle multiply/divide unit for the EX stage, handling MULT/MULTU/DIV/DIVU and the accumulating MADD/MADDU/MSUB/MSUBU forms. It sits beside the combinational EX sub-units and produces a 2×WIDTH {HI,LO} result for the HI/LO write path. While an operation is in flight it raises a stall request, so the pipeline holds the instruction in EX until the result is ready.

## Interface
- WIDTH, 32, operand width; the result is 2×WIDTH.
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- start_i  in  1  operation request; held high by the stalled pipeline until ready_o
- op_i  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU
- opdata1_i  in  WIDTH  rs operand (multiplicand / dividend)
- opdata2_i  in  WIDTH  rt operand (multiplier / divisor)
- hilo_i  in  2×WIDTH  forwarded {HI,LO} accumulator for MADD/MSUB
- annul_i  in  1  flush; aborts any in-flight operation
- result_o  out  2×WIDTH  {HI,LO}; for divides, HI = remainder and LO = quotient
- ready_o  out  1  result_o valid
- stall_o  out  1  stall request to pipeline control

## Operation
- States: IDLE, MUL, DIV_ON, DIV_ZERO, DONE.
- IDLE, on start_i=1 and annul_i=0:
  - latch op_i, opdata1_i, opdata2_i and hilo_i;
  - op 2/3 with divisor 0 → DIV_ZERO;
  - op 2/3 with nonzero divisor → DIV_ON, iteration counter = 0;
  - op 0,1,4–7 → MUL.
- MUL: forms the full 2×WIDTH product from the latched operands.
  - Signed for ops 0/4/6, unsigned for ops 1/5/7.
  - Ops 4/5: result = hilo + product. Ops 6/7: result = hilo − product. Both mod 2^(2W).
  - Registers the result, then → DONE.
- DIV_ON: restoring division, one quotient bit per cycle, on magnitudes for DIV.
  - After WIDTH iterations (counter reaches WIDTH−1), apply the sign fix-up, register the result, → DONE.
  - Signed quotient truncates toward zero; remainder takes the dividend's sign.
  - MIN / −1: quotient = MIN, remainder = 0.
- DIV_ZERO: result = {dividend, all-ones}, → DONE.
- DONE: ready_o=1, result_o held stable.
  - start_i=0 → IDLE.
  - start_i=1 → stay in DONE. The stalled instruction retires while start_i is still high; no new operation starts until start_i drops for at least one cycle.
- Abort: in MUL, DIV_ON or DIV_ZERO, annul_i=1 or start_i=0 → IDLE next cycle. No ready_o pulse; result_o is not updated.
- annul_i=1 in DONE → IDLE; ready_o drops next cycle.
- Inputs that change after latching are ignored until the next IDLE acceptance.
- stall_o = start_i & ~annul_i & ~ready_o (combinational).

## Timing
- Reset: state IDLE, result_o = 0, ready_o = 0, counter = 0. stall_o follows its equation (so it is 1 if start_i is high during reset).
- rst overrides everything, including mid-division; the unit is in IDLE on the cycle after rst.
- Start accepted in cycle N (IDLE). Latencies:
  - multiply family: ready_o in N+2;
  - divide by zero: ready_o in N+2;
  - divide: DIV_ON for cycles N+1..N+WIDTH, ready_o in N+WIDTH+1 (cycle 33 after start for WIDTH=32).
- result_o changes only on the edge entering DONE; it holds its value otherwise, including in IDLE.
- stall_o is 1 from cycle N through the last cycle before ready_o, and 0 in the ready cycle.
- Back-to-back: after DONE, start_i must be low for ≥1 cycle; the next operation is accepted on the first IDLE cycle with start_i=1.

## Test plan
- MULT 0xFFFFFFFF × 0x00000002 → result 0xFFFFFFFF_FFFFFFFE at N+2. MULTU with the same operands → 0x00000001_FFFFFFFE.
- MADD with hilo 0x00000000_00000001, operands 3 and 4 → 0x00000000_0000000D. MSUBU with hilo 0, operands 1 and 1 → 0xFFFFFFFF_FFFFFFFF.
- DIV −7 / 2 → HI = 0xFFFFFFFF, LO = 0xFFFFFFFD, ready_o at N+33, stall_o high for N..N+32. DIVU 0xFFFFFFFF / 0x10 → HI = 0xF, LO = 0x0FFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0. DIVU 5 / 0 → {0x00000005, 0xFFFFFFFF} at N+2.
- annul_i pulsed at N+10 of a divide → IDLE at N+11, ready_o never asserts, result_o keeps its prior value. A fresh MULT then completes normally.
- rst at N+5 of a divide → ready_o = 0, result_o = 0, state IDLE. start_i held through DONE does not restart the operation; a new request is accepted only after start_i drops.
